// File: rtl/dac_spi_pkg.sv
// Shared definitions for the MCP4911-class DAC SPI transmitter.
// Latency: n/a (types, constants and a frame-building helper only).
// Backpressure: n/a.
package dac_spi_pkg;

    localparam int FRAME_BITS   = 16;
    localparam int SCK_EDGES    = 2 * FRAME_BITS;

    // Frame field positions, MSB first on the wire.
    localparam int BIT_WR       = 15;
    localparam int BIT_BUF      = 14;
    localparam int BIT_GA       = 13;
    localparam int BIT_SHDN     = 12;
    localparam int BIT_DATA_MSB = 11;
    localparam int BIT_DATA_LSB = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_HOLD,
        ST_LDAC
    } state_e;

    // Write command to DAC A: config bits on top, sample left-justified, two pad zeros.
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic       buf_en,
        input logic       ga_n,
        input logic       shdn_n,
        input logic [9:0] sample
    );
        logic [FRAME_BITS-1:0] f;
        f                                = '0;
        f[BIT_WR]                        = 1'b0;
        f[BIT_BUF]                       = buf_en;
        f[BIT_GA]                        = ga_n;
        f[BIT_SHDN]                      = shdn_n;
        f[BIT_DATA_MSB:BIT_DATA_LSB]     = sample;
        return f;
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator: tick_o pulses once every DIV cycles.
// Latency: first tick DIV cycles after a clear; tick is combinational from the count.
// Backpressure: none; free-running except for synchronous clear.
module spi_clk_div #(
    parameter int unsigned DIV = 25
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned   CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Count 0..DIV-1 and wrap; a clear restarts the half-period so a frame starts phase-aligned.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/dac_spi_tx.sv
// SPI mode-0 transmitter for a 10-bit DAC; optional LDAC strobe when DAC_LDAC_EN is defined.
// Latency: cs_n falls on the load edge; frame is 33*CLK_DIV cycles (+CLK_DIV for the LDAC pulse).
// Backpressure: load is ignored (not queued) while busy is high.
module dac_spi_tx #(
    parameter int unsigned CLK_DIV = 25,
    parameter logic        GA_N    = 1'b1,
    parameter logic        BUF     = 1'b0,
    parameter logic        SHDN_N  = 1'b1
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic [9:0] data_in,
    input  logic       load,
    output logic       busy,
    output logic       dac_cs_n,
    output logic       dac_sck,
    output logic       dac_sdi,
    output logic       dac_ld_n
);
    import dac_spi_pkg::*;

    localparam logic [4:0] LAST_EDGE = 5'(SCK_EDGES - 1);

    state_e                state_q, state_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [4:0]            edge_q, edge_d;   // SCK edge count; edge_q[4:1] is the bit index
    logic                  cs_n_q, cs_n_d;
    logic                  sck_q, sck_d;
    logic                  sdi_q, sdi_d;
    logic                  busy_q, busy_d;
`ifdef DAC_LDAC_EN
    logic                  ld_n_q, ld_n_d;
`endif
    logic [FRAME_BITS-1:0] frame;
    logic                  div_clr;
    logic                  tick;

    assign frame = build_frame(BUF, GA_N, SHDN_N, data_in);

    spi_clk_div #(
        .DIV(CLK_DIV)
    ) u_clk_div (
        .clk_i  (sysclk),
        .rst_i  (reset),
        .clr_i  (div_clr),
        .tick_o (tick)
    );

    // Next-state and output decode; every SCK/CS/LDAC change happens on a half-period tick.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        edge_d  = edge_q;
        cs_n_d  = cs_n_q;
        sck_d   = sck_q;
        sdi_d   = sdi_q;
        busy_d  = busy_q;
`ifdef DAC_LDAC_EN
        ld_n_d  = ld_n_q;
`endif
        div_clr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    // First bit goes out with cs_n so it is settled a full half-period before SCK rises.
                    sdi_d   = frame[FRAME_BITS-1];
                    shift_d = {frame[FRAME_BITS-2:0], 1'b0};
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    edge_d  = '0;
                    div_clr = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (tick) begin
                    sck_d  = ~sck_q;
                    edge_d = edge_q + 1'b1;
                    // Data moves only as SCK falls; the last fall shifts in a trailing zero.
                    if (sck_q) begin
                        sdi_d   = shift_q[FRAME_BITS-1];
                        shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
                    end
                    if (edge_q == LAST_EDGE) begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    cs_n_d  = 1'b1;
`ifdef DAC_LDAC_EN
                    ld_n_d  = 1'b0;
                    state_d = ST_LDAC;
`else
                    // Without LDAC the DAC latches on cs_n rising, so the frame ends here.
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
`endif
                end
            end
            ST_LDAC: begin
`ifdef DAC_LDAC_EN
                if (tick) begin
                    ld_n_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and pin registers; reset abandons any frame in flight immediately.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            edge_q  <= '0;
            cs_n_q  <= 1'b1;
            sck_q   <= 1'b0;
            sdi_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef DAC_LDAC_EN
            ld_n_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            edge_q  <= edge_d;
            cs_n_q  <= cs_n_d;
            sck_q   <= sck_d;
            sdi_q   <= sdi_d;
            busy_q  <= busy_d;
`ifdef DAC_LDAC_EN
            ld_n_q  <= ld_n_d;
`endif
        end
    end

    assign busy     = busy_q;
    assign dac_cs_n = cs_n_q;
    assign dac_sck  = sck_q;
    assign dac_sdi  = sdi_q;
`ifdef DAC_LDAC_EN
    assign dac_ld_n = ld_n_q;
`else
    assign dac_ld_n = 1'b0;
`endif

endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: two instances (CLK_DIV=2 default config, CLK_DIV=3 with 2x gain).
// A pin-level monitor rebuilds frames and timing; a cycle-count model predicts accepted frames.
// Works with DAC_LDAC_EN defined or undefined.
module tb_dac_spi_tx;

    localparam int D0 = 2;
    localparam int D1 = 3;
`ifdef DAC_LDAC_EN
    localparam bit LDAC = 1'b1;
`else
    localparam bit LDAC = 1'b0;
`endif

    logic       sysclk = 1'b0;
    logic       reset  = 1'b1;
    logic [1:0] load   = 2'b00;
    logic [9:0] din0   = 10'd0;
    logic [9:0] din1   = 10'd0;
    logic [1:0] busy_w, cs_w, sck_w, sdi_w, ld_w;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 sysclk = ~sysclk;

    dac_spi_tx #(.CLK_DIV(D0)) u_dut0 (
        .sysclk(sysclk), .reset(reset), .data_in(din0), .load(load[0]),
        .busy(busy_w[0]), .dac_cs_n(cs_w[0]), .dac_sck(sck_w[0]),
        .dac_sdi(sdi_w[0]), .dac_ld_n(ld_w[0])
    );

    dac_spi_tx #(.CLK_DIV(D1), .GA_N(1'b0)) u_dut1 (
        .sysclk(sysclk), .reset(reset), .data_in(din1), .load(load[1]),
        .busy(busy_w[1]), .dac_cs_n(cs_w[1]), .dac_sck(sck_w[1]),
        .dac_sdi(sdi_w[1]), .dac_ld_n(ld_w[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int         edge_no     = 0;
    int         free_e[2]   = '{0, 0};
    int         exp_done[2] = '{0, 0};
    logic [15:0] q0[$];
    logic [15:0] q1[$];

    always @(posedge sysclk) edge_no <= edge_no + 1;

    function automatic int dv(input int i);
        return (i == 0) ? D0 : D1;
    endfunction

    function automatic int busy_len(input int i);
        return (LDAC ? 34 : 33) * dv(i);
    endfunction

    // Frame = write(0) | BUF(0) | GA_N | SHDN_N(1) | sample | 00.
    function automatic logic [15:0] model_frame(input int i, input logic [9:0] d);
        int ga;
        int f;
        ga = (i == 0) ? 1 : 0;
        f  = ga * 8192 + 4096 + int'(d) * 4;
        return 16'(f);
    endfunction

    // Called just after a posedge; load is sampled at the next edge.
    task automatic send(input int i, input logic [9:0] d);
        if (i == 0) din0 = d; else din1 = d;
        load[i] = 1'b1;
        if (edge_no + 1 >= free_e[i]) begin
            free_e[i] = edge_no + 1 + busy_len(i) + 1;
            exp_done[i]++;
            if (i == 0) q0.push_back(model_frame(0, d));
            else        q1.push_back(model_frame(1, d));
        end
        @(posedge sysclk); #1;
        load[i] = 1'b0;
        if (i == 0) din0 = 10'($urandom); else din1 = 10'($urandom);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic wait_idle(input int i);
        while (edge_no < free_e[i]) begin
            @(posedge sysclk); #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            if (edge_no + 1 < free_e[i]) begin
                exp_done[i]--;
                if (i == 0) void'(q0.pop_back()); else void'(q1.pop_back());
            end
            free_e[i] = 0;
        end
        step(1);
        reset = 1'b0;
    endtask

    // ---------------- pin monitor ----------------
    int          busy_run[2], cs_run[2], lo_run[2], hi_run[2], since_cs[2];
    int          ld_run[2], bits[2], frames_done[2], ld_pulses[2];
    logic [15:0] acc[2];
    logic [15:0] expf;
    logic [1:0]  p_busy, p_cs, p_sck, p_sdi, p_ld;
    logic        rst_prev;

    initial begin
        p_busy = 2'b00; p_cs = 2'b11; p_sck = 2'b00; p_sdi = 2'b00;
        p_ld = LDAC ? 2'b11 : 2'b00; rst_prev = 1'b0;
        for (int i = 0; i < 2; i++) begin
            busy_run[i] = 0; cs_run[i] = 0; lo_run[i] = 0; hi_run[i] = 0; since_cs[i] = -1;
            ld_run[i] = 0; bits[i] = 0; frames_done[i] = 0; ld_pulses[i] = 0; acc[i] = '0;
        end
        forever begin
            @(negedge sysclk);
            for (int i = 0; i < 2; i++) begin
                if (rst_prev) begin
                    check_eq($sformatf("%0d:rst_out", i),
                             32'({busy_w[i], cs_w[i], sck_w[i], sdi_w[i], ld_w[i]}),
                             32'({1'b0, 1'b1, 1'b0, 1'b0, LDAC}));
                    busy_run[i] = 0; cs_run[i] = 0; lo_run[i] = 0; hi_run[i] = 0;
                    since_cs[i] = -1; bits[i] = 0; ld_run[i] = 0;
                end else begin
                    if (since_cs[i] >= 0) since_cs[i]++;
                    if (busy_w[i]) busy_run[i]++;
                    if (!cs_w[i]) begin
                        if (p_cs[i]) begin
                            cs_run[i] = 0; bits[i] = 0; lo_run[i] = 0; hi_run[i] = 0;
                            acc[i] = '0; since_cs[i] = -1;
                        end
                        cs_run[i]++;
                        if (sck_w[i]) begin
                            if (!p_sck[i]) begin
                                check_eq($sformatf("%0d:sdi_stable", i), 32'(sdi_w[i]), 32'(p_sdi[i]));
                                check_eq($sformatf("%0d:sck_low", i), 32'(lo_run[i]), 32'(dv(i)));
                                acc[i] = {acc[i][14:0], sdi_w[i]};
                                bits[i]++;
                                lo_run[i] = 0;
                            end
                            hi_run[i]++;
                        end else begin
                            if (p_sck[i]) begin
                                check_eq($sformatf("%0d:sck_high", i), 32'(hi_run[i]), 32'(dv(i)));
                                hi_run[i] = 0;
                            end
                            lo_run[i]++;
                        end
                    end else if (!p_cs[i]) begin
                        check_eq($sformatf("%0d:cs_len", i), 32'(cs_run[i]), 32'(33 * dv(i)));
                        check_eq($sformatf("%0d:bits", i), 32'(bits[i]), 32'd16);
                        check_eq($sformatf("%0d:sck_at_cs_rise", i), 32'(sck_w[i]), 32'd0);
                        if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                            check_eq($sformatf("%0d:unexpected_frame", i), 32'(acc[i]), 32'hFFFF_FFFF);
                        end else begin
                            if (i == 0) expf = q0.pop_front(); else expf = q1.pop_front();
                            check_eq($sformatf("%0d:frame", i), 32'(acc[i]), 32'(expf));
                        end
                        frames_done[i]++;
                        since_cs[i] = 0;
                    end
                    if (p_ld[i] && !ld_w[i]) begin
                        check_eq($sformatf("%0d:ld_after_cs", i), 32'(since_cs[i]), 32'd0);
                        ld_run[i] = 0;
                    end
                    if (!ld_w[i]) ld_run[i]++;
                    if (!p_ld[i] && ld_w[i]) begin
                        check_eq($sformatf("%0d:ld_len", i), 32'(ld_run[i]), 32'(dv(i)));
                        ld_pulses[i]++;
                    end
                    if (p_busy[i] && !busy_w[i]) begin
                        check_eq($sformatf("%0d:busy_len", i), 32'(busy_run[i]), 32'(busy_len(i)));
                        check_eq($sformatf("%0d:busy_vs_cs", i), 32'(since_cs[i]), 32'(LDAC ? dv(i) : 0));
                        busy_run[i] = 0;
                    end
                end
            end
            p_busy = busy_w; p_cs = cs_w; p_sck = sck_w; p_sdi = sdi_w; p_ld = ld_w;
            rst_prev = reset;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        step(3);
        reset = 1'b0;

        // Idle after reset.
        repeat (100) begin
            @(negedge sysclk);
            for (int i = 0; i < 2; i++)
                check_eq($sformatf("%0d:idle", i),
                         32'({busy_w[i], cs_w[i], sck_w[i], sdi_w[i], ld_w[i]}),
                         32'({1'b0, 1'b1, 1'b0, 1'b0, LDAC}));
        end
        step(1);

        // Directed frames, including the 2x-gain instance.
        send(0, 10'h2AA); wait_idle(0);
        send(0, 10'h3FF); send(1, 10'h000); wait_idle(0);
        send(0, 10'h000); wait_idle(0); wait_idle(1);

        // Second load 10 cycles into a frame must be dropped.
        send(0, 10'h155); step(9); send(0, 10'h0F0); wait_idle(0);

        // Reset at bit 7, then a clean frame.
        send(0, 10'h3C3); step(28); do_reset();
        @(negedge sysclk);
        check_eq("abort_state", 32'({busy_w[0], cs_w[0], sck_w[0]}), 32'({1'b0, 1'b1, 1'b0}));
        step(1);
        send(0, 10'h24B); wait_idle(0);

        // Load together with reset: reset wins.
        reset = 1'b1; load[0] = 1'b1; din0 = 10'h111;
        step(1);
        reset = 1'b0; load[0] = 1'b0;
        @(negedge sysclk);
        check_eq("load_with_reset", 32'({busy_w[0], cs_w[0]}), 32'({1'b0, 1'b1}));
        step(1);

        // Random traffic; loads landing while busy are dropped by the model.
        for (int n = 0; n < 24; n++) begin
            send(int'($urandom_range(0, 1)), 10'($urandom));
            step(int'($urandom_range(0, 90)));
        end
        wait_idle(0); wait_idle(1); step(10);

        for (int i = 0; i < 2; i++) begin
            check_eq($sformatf("%0d:frames", i), 32'(frames_done[i]), 32'(exp_done[i]));
            check_eq($sformatf("%0d:ld_pulses", i), 32'(ld_pulses[i]), 32'(LDAC ? exp_done[i] : 0));
        end
        check_eq("q0_left", 32'(q0.size()), 32'd0);
        check_eq("q1_left", 32'(q1.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
